ifeed_ctrl: RTL and testbench

//  Upstream feeder for the row IBuffers of the MAC array. Reads NumTiles x ROWS
//  32-bit input words from a 1-cycle-latency SRAM and issues one word plus a
//  1-cycle EN pulse per IBuffer row.

---
 rtl/ifeed_ctrl_if.sv | 36 +++
 rtl/ifeed_ctrl.sv | 135 +++++++++++++
 tb/tb_ifeed_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ifeed_ctrl_if.sv
// Bundle of the ifeed_ctrl run-control, SRAM read and IBuffer row ports.
// Pass-through only, so it adds no latency.
// No backpressure: the SRAM has a fixed 1-cycle read, and the IBuffers accept every EN pulse.
// IFEED_PAUSE_EN adds the Pause input.
interface ifeed_ctrl_if #(
  parameter int ROWS = 4,
  parameter int AW   = 8
);
  logic                 Start;
  logic [AW-1:0]        BaseAddr;
  logic [7:0]           NumTiles;
  logic                 MemRd;
  logic [AW-1:0]        MemAddr;
  logic [31:0]          MemRData;
  logic [ROWS*32-1:0]   IWord;
  logic [ROWS-1:0]      EN;
  logic                 Busy;
  logic                 Done;
`ifdef IFEED_PAUSE_EN
  logic                 Pause;

  // Controller side
  modport master (input Start, BaseAddr, NumTiles, MemRData, Pause,
                  output MemRd, MemAddr, IWord, EN, Busy, Done);
  // Host / SRAM / IBuffer side
  modport slave  (output Start, BaseAddr, NumTiles, MemRData, Pause,
                  input MemRd, MemAddr, IWord, EN, Busy, Done);
`else
  // Controller side
  modport master (input Start, BaseAddr, NumTiles, MemRData,
                  output MemRd, MemAddr, IWord, EN, Busy, Done);
  // Host / SRAM / IBuffer side
  modport slave  (output Start, BaseAddr, NumTiles, MemRData,
                  input MemRd, MemAddr, IWord, EN, Busy, Done);
`endif
endinterface

// File: rtl/ifeed_ctrl.sv
// Feeds NumTiles x ROWS SRAM words to the row IBuffers, with the rows skewed one cycle apart.
// Latency: Start to EN[0] is 3 cycles, and Start to Done is 4*NumTiles+3 cycles.
// Backpressure: none by default. IFEED_PAUSE_EN adds Pause, which holds a tile at phase 0.
module ifeed_ctrl #(
  parameter int ROWS = 4,
  parameter int AW   = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  ifeed_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0]    ROWS_W = 3'(ROWS);
  localparam logic [AW-1:0] ROWS_A = AW'(ROWS);

  state_t               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [7:0]           tile_q, tile_d;
  logic [7:0]           num_q, num_d;
  logic [AW-1:0]        base_q, base_d;
  logic                 drain_q, drain_d;
  logic                 rd_vld_q, rd_vld_d;   // read issued last cycle, data on MemRData now
  logic [1:0]           rd_row_q, rd_row_d;
  logic [ROWS-1:0]      en_q, en_d;
  logic [ROWS*32-1:0]   iword_q, iword_d;

  logic                 pause;
  logic                 hold;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;

`ifdef IFEED_PAUSE_EN
  assign pause = bus.Pause;
`else
  assign pause = 1'b0;
`endif

  // Read decode: phase p of a tile reads row p of that tile, and phases at or above ROWS are idle
  always_comb begin
    hold    = (state_q == RUN) && (phase_q == 2'd0) && pause;
    rd_en   = (state_q == RUN) && ({1'b0, phase_q} < ROWS_W) && !hold;
    rd_addr = base_q + AW'(tile_q) * ROWS_A + AW'(phase_q);
  end

  // Next state for the sequencing FSM, the read pipeline and the row registers
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tile_d   = tile_q;
    num_d    = num_q;
    base_d   = base_q;
    drain_d  = drain_q;
    rd_vld_d = rd_en;
    rd_row_d = phase_q;
    en_d     = '0;
    iword_d  = iword_q;

    // The data returns one cycle after the read and lands in the row selected at issue time
    for (int r = 0; r < ROWS; r++) begin
      if (rd_vld_q && (rd_row_q == 2'(r))) begin
        en_d[r]            = 1'b1;
        iword_d[r*32 +: 32] = bus.MemRData;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          base_d  = bus.BaseAddr;
          num_d   = bus.NumTiles;
          tile_d  = 8'd0;
          phase_d = 2'd0;
          state_d = (bus.NumTiles == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (tile_q == num_q - 8'd1) begin
              state_d = DRAIN;
              drain_d = 1'b0;
            end else begin
              tile_d = tile_q + 8'd1;
            end
          end
        end
      end
      // Two cycles, which let the last row's read return and its EN go out
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers. The asynchronous reset aborts a run without emitting Done
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      tile_q   <= '0;
      num_q    <= '0;
      base_q   <= '0;
      drain_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_row_q <= '0;
      en_q     <= '0;
      iword_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      tile_q   <= tile_d;
      num_q    <= num_d;
      base_q   <= base_d;
      drain_q  <= drain_d;
      rd_vld_q <= rd_vld_d;
      rd_row_q <= rd_row_d;
      en_q     <= en_d;
      iword_q  <= iword_d;
    end
  end

  assign bus.MemRd   = rd_en;
  assign bus.MemAddr = rd_en ? rd_addr : '0;
  assign bus.EN      = en_q;
  assign bus.IWord   = iword_q;
  assign bus.Busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.Done    = (state_q == DONE);

endmodule

// File: tb/tb_ifeed_ctrl.sv
module tb_ifeed_ctrl;

  logic CLK = 1'b0;
  logic RSTN;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  ifeed_ctrl_if #(.ROWS(4), .AW(8)) bus ();

  ifeed_ctrl #(.ROWS(4), .AW(8)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  // SRAM model: 1-cycle read latency, mem[a] = a * 0x01010101
  always @(posedge CLK) begin
    if (bus.MemRd) bus.MemRData <= {4{bus.MemAddr}};
  end

  typedef struct {
    logic        start;
    logic [7:0]  base;
    logic [7:0]  num;
    logic        rd;
    logic [7:0]  addr;
    logic [3:0]  en;
    logic [31:0] w;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic start, logic [7:0] base, logic [7:0] num, logic rd,
                              logic [7:0] addr, logic [3:0] en, logic [31:0] w,
                              logic busy, logic done);
    vec_t v;
    v.start = start; v.base = base; v.num = num; v.rd = rd; v.addr = addr;
    v.en = en; v.w = w; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_outputs(string nm);
    chk({nm, " rd"},    bus.MemRd, 1'b0);
    chk({nm, " addr"},  bus.MemAddr, 8'h00);
    chk({nm, " en"},    bus.EN, 4'h0);
    chk({nm, " iword"}, bus.IWord, 128'h0);
    chk({nm, " busy"},  bus.Busy, 1'b0);
    chk({nm, " done"},  bus.Done, 1'b0);
  endtask

  initial begin
    logic        e_rd;
    logic [7:0]  e_addr;
    logic [3:0]  e_en;
    int          k;

    RSTN         = 1'b0;
    bus.Start    = 1'b0;
    bus.BaseAddr = '0;
    bus.NumTiles = '0;
`ifdef IFEED_PAUSE_EN
    bus.Pause    = 1'b0;
`endif

    // Test 1, then a Start during DONE (ignored)
    vt.push_back(mk(1, 8'h10, 8'd1, 0, 8'h00, 4'h0, 32'h0,        0, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'h10, 4'h0, 32'h0,        1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'h11, 4'h0, 32'h0,        1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'h12, 4'h1, 32'h10101010, 1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'h13, 4'h2, 32'h11111111, 1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h4, 32'h12121212, 1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h8, 32'h13131313, 1, 0));
    vt.push_back(mk(1, 8'h80, 8'd1, 0, 8'h00, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h0, 32'h0,        0, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h0, 32'h0,        0, 0));
    // Test 3: NumTiles = 0
    vt.push_back(mk(1, 8'h20, 8'd0, 0, 8'h00, 4'h0, 32'h0,        0, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h0, 32'h0,        0, 0));
    // Test 4: address wrap
    vt.push_back(mk(1, 8'hFE, 8'd1, 0, 8'h00, 4'h0, 32'h0,        0, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'hFE, 4'h0, 32'h0,        1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'hFF, 4'h0, 32'h0,        1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'h00, 4'h1, 32'hFEFEFEFE, 1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 1, 8'h01, 4'h2, 32'hFFFFFFFF, 1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h4, 32'h00000000, 1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h8, 32'h01010101, 1, 0));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h0, 32'h0,        0, 1));
    vt.push_back(mk(0, 8'h00, 8'd0, 0, 8'h00, 4'h0, 32'h0,        0, 0));

    // Reset state
    tick();
    @(negedge CLK);
    chk_idle_outputs("reset");
    tick();
    RSTN = 1'b1;

    // Table-driven vectors
    foreach (vt[i]) begin
      tick();
      bus.Start    = vt[i].start;
      bus.BaseAddr = vt[i].base;
      bus.NumTiles = vt[i].num;
      @(negedge CLK);
      chk($sformatf("vec%0d rd", i), bus.MemRd, vt[i].rd);
      if (vt[i].rd) chk($sformatf("vec%0d addr", i), bus.MemAddr, vt[i].addr);
      chk($sformatf("vec%0d en", i), bus.EN, vt[i].en);
      chk($sformatf("vec%0d busy", i), bus.Busy, vt[i].busy);
      chk($sformatf("vec%0d done", i), bus.Done, vt[i].done);
      for (int r = 0; r < 4; r++)
        if (vt[i].en[r]) chk($sformatf("vec%0d iword%0d", i, r), bus.IWord[r*32 +: 32], vt[i].w);
    end
    tick();
    bus.Start = 1'b0;

    // Tests 2 and 5: three tiles, with a Start re-pulse in cycle 5 using different operands
    for (int c = 0; c <= 16; c++) begin
      tick();
      bus.Start    = (c == 0) || (c == 5);
      bus.BaseAddr = (c == 5) ? 8'h40 : 8'h10;
      bus.NumTiles = (c == 5) ? 8'd1 : 8'd3;
      @(negedge CLK);
      e_rd   = (c >= 1) && (c <= 12);
      e_addr = e_rd ? 8'(8'h10 + c - 1) : 8'h00;
      for (int r = 0; r < 4; r++) begin
        k = c - 3 - r;
        e_en[r] = (k >= 0) && (k % 4 == 0) && (k / 4 < 3);
      end
      chk($sformatf("t2 c%0d rd", c), bus.MemRd, e_rd);
      chk($sformatf("t2 c%0d addr", c), bus.MemAddr, e_addr);
      chk($sformatf("t2 c%0d en", c), bus.EN, e_en);
      chk($sformatf("t2 c%0d busy", c), bus.Busy, (c >= 1) && (c <= 14));
      chk($sformatf("t2 c%0d done", c), bus.Done, c == 15);
      for (int r = 0; r < 4; r++)
        if (e_en[r]) chk($sformatf("t2 c%0d iword%0d", c, r), bus.IWord[r*32 +: 32],
                         {4{8'(8'h10 + 4 * ((c - 3 - r) / 4) + r)}});
    end
    bus.Start = 1'b0;

    // Reset in the middle of a run
    for (int c = 0; c <= 6; c++) begin
      tick();
      bus.Start    = (c == 0);
      bus.BaseAddr = 8'h10;
      bus.NumTiles = 8'd3;
      if (c == 6) RSTN = 1'b0;
    end
    @(negedge CLK);
    chk_idle_outputs("midrst");
    tick();
    tick();
    RSTN = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      chk($sformatf("postrst c%0d done", c), bus.Done, 1'b0);
      chk($sformatf("postrst c%0d busy", c), bus.Busy, 1'b0);
      tick();
    end

    // A fresh run after the reset completes normally
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      bus.Start    = (c == 0);
      bus.BaseAddr = 8'h30;
      bus.NumTiles = 8'd1;
      @(negedge CLK);
      chk($sformatf("rerun c%0d en0", c), bus.EN[0], c == 3);
      chk($sformatf("rerun c%0d done", c), bus.Done, c == 7);
      if (c == 7) chk("rerun iword", bus.IWord,
                      128'h33333333_32323232_31313131_30303030);
    end
    bus.Start = 1'b0;

`ifdef IFEED_PAUSE_EN
    // Pause at phase 2 (cycle 3) is ignored. Pause in cycles 5-6 delays tile 1 to cycles 7-10
    tick();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) tick();
      bus.Start    = (c == 0);
      bus.BaseAddr = 8'h10;
      bus.NumTiles = 8'd2;
      bus.Pause    = (c == 3) || (c == 5) || (c == 6);
      @(negedge CLK);
      e_rd = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 10));
      chk($sformatf("pause c%0d rd", c), bus.MemRd, e_rd);
      if (e_rd) chk($sformatf("pause c%0d addr", c), bus.MemAddr,
                    8'(8'h10 + ((c <= 4) ? c - 1 : c - 3)));
      chk($sformatf("pause c%0d busy", c), bus.Busy, (c >= 1) && (c <= 12));
      chk($sformatf("pause c%0d done", c), bus.Done, c == 13);
    end
    bus.Start = 1'b0;
    bus.Pause = 1'b0;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
